// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants and helpers for the display blocks.
// Segment codes are held active-low as {dp,g,f,e,d,c,b,a}; drivers invert for active-high parts.
package seven_seg_pkg;

  localparam logic [7:0] SEG_0       = 8'hC0;
  localparam logic [7:0] SEG_1       = 8'hF9;
  localparam logic [7:0] SEG_2       = 8'hA4;
  localparam logic [7:0] SEG_3       = 8'hB0;
  localparam logic [7:0] SEG_4       = 8'h99;
  localparam logic [7:0] SEG_5       = 8'h92;
  localparam logic [7:0] SEG_6       = 8'h82;
  localparam logic [7:0] SEG_7       = 8'hF8;
  localparam logic [7:0] SEG_8       = 8'h80;
  localparam logic [7:0] SEG_9       = 8'h90;
  localparam logic [7:0] SEG_DASH    = 8'hBF;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DP_MASK = 8'h7F;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
    logic [7:0] code;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_scan_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, then a single commit cycle.
// The visible BCD register only changes on commit, so the display never shows a partial result.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W    = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      value_i,
  output logic                    busy_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    overflow_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (clog2(VALUE_W) < 1) ? 1 : clog2(VALUE_W);

  conv_state_e        state_q;
  logic [VALUE_W-1:0] shift_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_work_q;
  logic               ovf_q;
  logic               busy_q;

  always_comb begin
    work_adj = work_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (work_q[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
    end
  end

  // Only NUM_DIGITS nibbles are kept; any bit shifted out of the top one means value >= 10**NUM_DIGITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CONV_IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_work_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start_i) begin
            shift_q    <= value_i;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_work_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          work_q     <= {work_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
          shift_q    <= shift_q << 1;
          ovf_work_q <= ovf_work_q | work_adj[BCD_W-1];
          cnt_q      <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(VALUE_W - 1)) state_q <= CONV_COMMIT;
        end
        CONV_COMMIT: begin
          bcd_q   <= work_q;
          ovf_q   <= ovf_work_q;
          busy_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
        default: state_q <= CONV_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit seven-segment driver for the shot-clock display: scan divider,
// digit index, blink phase, blanking and the registered segment/anode outputs.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 16,
  parameter int CLK_HZ      = 100000000,
  parameter int SCAN_HZ     = 1000,
  parameter int BLINK_HZ    = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    display_value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lz_blank,
  input  logic                  blink_en,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy
);

  localparam int DIV_RAW  = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DWELL_W  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam int BLINK_W  = (clog2(HALF) < 1) ? 1 : clog2(HALF);
  localparam int IDX_W    = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam int BCD_W    = 4 * NUM_DIGITS;

  localparam logic [7:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic                  conv_start;
  logic                  conv_busy;
  logic [BCD_W-1:0]      bcd;
  logic                  overflow;

  logic [VALUE_W-1:0]    last_q, last_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [NUM_DIGITS-1:0] lead_zero;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [7:0]            digit_code;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (conv_start),
    .value_i    (display_value),
    .busy_o     (conv_busy),
    .bcd_o      (bcd),
    .overflow_o (overflow)
  );

  always_comb begin
    conv_start  = !conv_busy && (display_value != last_q);
    last_d      = conv_start ? display_value : last_q;
    dwell_d     = dwell_q + DWELL_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_on_d  = blink_on_q;
    if (dwell_q == DWELL_W'(DIV - 1)) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    if (blink_cnt_q == BLINK_W'(HALF - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      all_zero     = all_zero && (bcd[4*d +: 4] == 4'd0);
      lead_zero[d] = all_zero;
    end
    digit_code = seg_encode(bcd[4*int'(idx_q) +: 4]);
    if (overflow) begin
      digit_code = SEG_DASH;
    end else if (lz_blank && (idx_q != '0) && lead_zero[idx_q]) begin
      digit_code = SEG_BLANK;
    end
    if (dp_mask[idx_q]) digit_code = digit_code & SEG_DP_MASK;
    seg_d = (SEG_ACT_LOW != 0) ? digit_code : ~digit_code;
    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;
    if (blink_en && !blink_on_q) begin
      an_d = AN_OFF;
    end else begin
      an_d = (AN_ACT_LOW != 0) ? ~an_onehot : an_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= '0;
      dwell_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      last_q      <= last_d;
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg_data = seg_q;
  assign an       = an_q;
  assign busy     = conv_busy;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed and randomized bench for seven_seg_scan using a decimal-arithmetic display model.
module tb_seven_seg_scan;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [VALUE_W-1:0]    display_value = '0;
  logic [NUM_DIGITS-1:0] dp_mask = '0;
  logic                  lz_blank = 1'b0;
  logic                  blink_en = 1'b0;
  logic [7:0]            seg_data;
  logic [NUM_DIGITS-1:0] an;
  logic                  busy;

  int          tests = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        blinkSeen = 1'b0;
  int unsigned shownVal = 0;
  logic [7:0]  segTable [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seven_seg_scan #(
    .NUM_DIGITS  (NUM_DIGITS),
    .VALUE_W     (VALUE_W),
    .CLK_HZ      (4000),
    .SCAN_HZ     (250),
    .BLINK_HZ    (250),
    .SEG_ACT_LOW (1),
    .AN_ACT_LOW  (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_value (display_value),
    .dp_mask       (dp_mask),
    .lz_blank      (lz_blank),
    .blink_en      (blink_en),
    .seg_data      (seg_data),
    .an            (an),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; blink_en as seen by the edge that produced the outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      blinkSeen <= 1'b0;
    end else begin
      cyc       <= cyc + 1;
      blinkSeen <= blink_en;
    end
  end

  function automatic logic [7:0] expSeg(input int unsigned v, input int idx,
                                        input logic lz, input logic [3:0] dp);
    int unsigned p;
    logic [7:0]  c;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (v >= 10000) c = 8'hBF;
    else if (lz && idx > 0 && v < p) c = 8'hFF;
    else c = segTable[(v / p) % 10];
    if (dp[idx]) c[7] = 1'b0;
    return c;
  endfunction

  task automatic checkOne(input string tag);
    int         idx;
    logic       off;
    logic [3:0] ea;
    logic [7:0] es;
    idx = ((cyc - 1) / 4) % 4;
    off = blinkSeen && ((((cyc - 1) / 8) % 2) == 1);
    ea  = off ? 4'hF : ~(4'b0001 << idx);
    es  = expSeg(shownVal, idx, lz_blank, dp_mask);
    tests++;
    assert (an === ea) else begin
      failures++;
      $error("[TB] FAIL %s an: observed=%b expected=%b (cycle %0d)", tag, an, ea, cyc);
    end
    if (!off) begin
      tests++;
      assert (seg_data === es) else begin
        failures++;
        $error("[TB] FAIL %s seg: observed=%h expected=%h (digit %0d, cycle %0d)", tag, seg_data, es, idx, cyc);
      end
    end
  endtask

  task automatic checkOutput(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOne(tag);
    end
  endtask

  task automatic applyStimulus(input int unsigned v, input logic [3:0] dp,
                               input logic lz, input logic bl);
    @(negedge clk);
    display_value = VALUE_W'(v);
    dp_mask       = dp;
    lz_blank      = lz;
    blink_en      = bl;
  endtask

  // Old value must stay on display while busy; busy must last VALUE_W+1 cycles.
  task automatic waitConversion(input int unsigned newVal, input int midAt,
                                input int unsigned midVal, input string tag);
    int n;
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      checkOne(tag);
      guard++;
    end while (busy !== 1'b1 && guard < 3);
    tests++;
    assert (busy === 1'b1) else begin
      failures++;
      $error("[TB] FAIL %s busy-rise: observed=%b expected=1", tag, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == midAt) display_value = VALUE_W'(midVal);
      @(negedge clk);
      checkOne(tag);
    end
    tests++;
    assert (n == 17) else begin
      failures++;
      $error("[TB] FAIL %s busy-length: observed=%0d expected=17", tag, n);
    end
    shownVal = newVal;
  endtask

  initial begin
    int unsigned rv;

    // 1: outputs held off during reset regardless of inputs
    display_value = VALUE_W'($urandom);
    dp_mask       = 4'($urandom);
    lz_blank      = 1'($urandom);
    blink_en      = 1'($urandom);
    repeat (3) @(negedge clk);
    tests++;
    assert (seg_data === 8'hFF) else begin
      failures++;
      $error("[TB] FAIL reset seg: observed=%h expected=ff", seg_data);
    end
    tests++;
    assert (an === 4'hF) else begin
      failures++;
      $error("[TB] FAIL reset an: observed=%b expected=1111", an);
    end
    tests++;
    assert (busy === 1'b0) else begin
      failures++;
      $error("[TB] FAIL reset busy: observed=%b expected=0", busy);
    end
    display_value = '0;
    dp_mask       = '0;
    lz_blank      = 1'b0;
    blink_en      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    shownVal = 0;
    checkOutput(16, "release");

    // 2: 24 without blanking
    applyStimulus(24, 4'b0000, 1'b0, 1'b0);
    waitConversion(24, -1, 0, "v24");
    checkOutput(32, "v24");

    // 3: leading-zero blanking with a DP on a blanked digit
    applyStimulus(24, 4'b0100, 1'b1, 1'b0);
    checkOutput(16, "v24-lz-dp");

    // 4: overflow dashes, then back to zero
    applyStimulus(12345, 4'b0000, 1'b1, 1'b0);
    waitConversion(12345, -1, 0, "ovf");
    checkOutput(16, "ovf");
    applyStimulus(12345, 4'b1001, 1'b1, 1'b0);
    checkOutput(16, "ovf-dp");
    applyStimulus(0, 4'b0000, 1'b0, 1'b0);
    waitConversion(0, -1, 0, "zero");
    checkOutput(16, "zero");

    // 5: change mid-conversion is deferred until after commit
    applyStimulus(24, 4'b0000, 1'b0, 1'b0);
    waitConversion(24, 5, 23, "mid24");
    waitConversion(23, -1, 0, "mid23");
    checkOutput(16, "mid23");

    // Randomized values, blanking and DP masks
    for (int i = 0; i < 6; i++) begin
      do rv = $urandom_range(0, 12000); while (rv == shownVal);
      applyStimulus(rv, 4'($urandom), 1'($urandom), 1'b0);
      waitConversion(rv, -1, 0, "rand");
      checkOutput(16, "rand");
    end
    applyStimulus(65535, 4'b0000, 1'b0, 1'b0);
    waitConversion(65535, -1, 0, "max");
    checkOutput(16, "max");

    // 6: blinking zero, then asynchronous reset mid-scan
    applyStimulus(0, 4'b0000, 1'b0, 1'b1);
    waitConversion(0, -1, 0, "blink");
    checkOutput(40, "blink");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    assert (seg_data === 8'hFF) else begin
      failures++;
      $error("[TB] FAIL async-reset seg: observed=%h expected=ff", seg_data);
    end
    tests++;
    assert (an === 4'hF) else begin
      failures++;
      $error("[TB] FAIL async-reset an: observed=%b expected=1111", an);
    end
    @(negedge clk);
    rst_n = 1'b1;
    shownVal = 0;
    checkOutput(24, "post-reset-blink");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
